// File: rtl/ioctl_upload_server_pkg.sv
// ioctl_upload_server_pkg: shared ioctl index constants and upload FSM state type
package ioctl_upload_server_pkg;

    localparam logic [7:0] IDX_ROM = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PREFETCH
    } upload_state_t;

endpackage

// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server: answers HPS upload reads from core memory, prefetching addr+1 to avoid stalls
module ioctl_upload_server
    import ioctl_upload_server_pkg::*;
#(
    parameter int          ADDR_W = 17,
    parameter logic [7:0]  INDEX  = IDX_ROM,
    parameter logic [24:0] LIMIT  = 25'h1FFFF,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    upload_state_t     state;
    logic              wait_r;
    logic              upl_q;
    logic              discard;
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic [7:0]        pf_data;
    logic              pend_valid;
    logic [24:0]       pend_addr;
    logic              act;
    logic              edge_u;
    logic [24:0]       req_addr;
    logic              oor;
    logic              pmatch;
    logic              hit;
    logic              idle_miss;
    logic              pf_read;
    logic [ADDR_W-1:0] inc_base;
    logic [ADDR_W:0]   nxt;
    logic              nxt_ok;

    // Decode the incoming strobe against the prefetch buffer and work out the follow-on address
    always_comb begin
        act       = ioctl_rd && ioctl_upload && (ioctl_index == INDEX) && !wait_r;
        edge_u    = ioctl_upload ^ upl_q;
        req_addr  = (state == PREFETCH && pend_valid) ? pend_addr : ioctl_addr;
        oor       = req_addr > LIMIT;
        pmatch    = !oor && (req_addr[ADDR_W-1:0] == pf_addr);
        hit       = pf_valid && !edge_u && pmatch;
        idle_miss = (state == IDLE) && act && !oor && !hit;
        pf_read   = (state == PREFETCH) && act && !edge_u && !discard;
        inc_base  = (state == FETCH) ? mem_addr : req_addr[ADDR_W-1:0];
        nxt       = {1'b0, inc_base} + (ADDR_W+1)'(1);
        nxt_ok    = !nxt[ADDR_W] && (25'(nxt) <= LIMIT);
    end

    assign ioctl_wait = wait_r | idle_miss | pf_read;

    // Upload FSM: serve reads, run fetch/prefetch memory transactions, hold one pending read
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ioctl_din  <= '0;
            wait_r     <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            pf_valid   <= 1'b0;
            pf_addr    <= '0;
            pf_data    <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            discard    <= 1'b0;
            upl_q      <= 1'b0;
        end else begin
            upl_q <= ioctl_upload;
            case (state)
                IDLE: begin
                    if (edge_u) pf_valid <= 1'b0;
                    if (act) begin
                        if (oor) begin
                            ioctl_din <= FILL;
                        end else if (hit) begin
                            ioctl_din <= pf_data;
                            pf_valid  <= 1'b0;
                            if (nxt_ok) begin
                                pf_addr  <= nxt[ADDR_W-1:0];
                                mem_addr <= nxt[ADDR_W-1:0];
                                state    <= PREFETCH;
                            end
                        end else begin
                            wait_r   <= 1'b1;
                            pf_valid <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= req_addr[ADDR_W-1:0];
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (edge_u) begin
                        discard <= 1'b1;
                        wait_r  <= 1'b0;
                    end
                    if (!mem_req) begin
                        if (discard || edge_u) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            mem_req <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        if (discard || edge_u) begin
                            state <= IDLE;
                        end else begin
                            ioctl_din <= mem_rdata;
                            wait_r    <= 1'b0;
                            if (nxt_ok) begin
                                pf_addr  <= nxt[ADDR_W-1:0];
                                mem_addr <= nxt[ADDR_W-1:0];
                                state    <= PREFETCH;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                PREFETCH: begin
                    if (edge_u) begin
                        discard    <= 1'b1;
                        wait_r     <= 1'b0;
                        pend_valid <= 1'b0;
                    end
                    if (pf_read) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ioctl_addr;
                        wait_r     <= 1'b1;
                    end
                    if (!mem_req) begin
                        if (discard || edge_u) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            mem_req <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        if (discard || edge_u) begin
                            pend_valid <= 1'b0;
                            wait_r     <= 1'b0;
                            state      <= IDLE;
                        end else if (pend_valid || pf_read) begin
                            pend_valid <= 1'b0;
                            if (pmatch) begin
                                ioctl_din <= mem_rdata;
                                wait_r    <= 1'b0;
                                if (nxt_ok) begin
                                    pf_addr  <= nxt[ADDR_W-1:0];
                                    mem_addr <= nxt[ADDR_W-1:0];
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (oor) begin
                                ioctl_din <= FILL;
                                wait_r    <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                wait_r   <= 1'b1;
                                mem_addr <= req_addr[ADDR_W-1:0];
                                state    <= FETCH;
                            end
                        end else begin
                            pf_data  <= mem_rdata;
                            pf_valid <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// tb_ioctl_upload_server: scoreboard bench for the ioctl upload server with a latency-configurable memory model
module tb_ioctl_upload_server;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_index = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          lat = 3;
    logic [7:0]  exp_q[$];
    logic [16:0] txn_q[$];

    ioctl_upload_server dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_index  (ioctl_index),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] mem_byte(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ {a[16], 7'h2D};
    endfunction

    // memory model: acks each request after lat sampled cycles and logs the served address
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_byte({8'h00, mem_addr});
                    txn_q.push_back(mem_addr);
                    cnt = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_read(input logic [24:0] a, output logic w0, output logic [7:0] got, output int cyc);
        exp_q.push_back(a > 25'h1FFFF ? 8'hFF : mem_byte(a));
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        ioctl_index = 8'h00;
        @(negedge clk_sys);
        w0 = ioctl_wait;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        cyc = -1;
        got = 'x;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (!ioctl_wait) begin
                cyc = i;
                got = ioctl_din;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (ioctl_din !== 8'h00) $display("FAIL reset_din: got %h want 00", ioctl_din); else n_pass++;
        n_checks++; if (ioctl_wait !== 1'b0) $display("FAIL reset_wait: got %b want 0", ioctl_wait); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 17'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        tick(1);
        ioctl_upload = 1'b1;
        tick(2);
    endtask

    task automatic test_cold_read();
        logic w0; logic [7:0] got; logic [7:0] e; int cyc;
        lat = 3;
        txn_q.delete();
        do_read(25'h10, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (w0 !== 1'b1) $display("FAIL cold_wait_strobe: got %b want 1", w0); else n_pass++;
        n_checks++; if (cyc != 3) $display("FAIL cold_wait_cycles: got %0d want 3", cyc); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL cold_din: got %h want %h", got, e); else n_pass++;
        tick(8);
        n_checks++; if (txn_q.size() != 2 || txn_q[1] !== 17'h11) $display("FAIL cold_prefetch: got n=%0d last=%h want n=2 last=00011", txn_q.size(), txn_q[txn_q.size()-1]); else n_pass++;
    endtask

    task automatic test_prefetch_hit();
        logic w0; logic [7:0] got; logic [7:0] e; int cyc;
        txn_q.delete();
        do_read(25'h11, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (w0 !== 1'b0) $display("FAIL hit_wait_strobe: got %b want 0", w0); else n_pass++;
        n_checks++; if (cyc != 0) $display("FAIL hit_wait_cycles: got %0d want 0", cyc); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL hit_din: got %h want %h", got, e); else n_pass++;
        tick(8);
        n_checks++; if (txn_q.size() != 1 || txn_q[0] !== 17'h12) $display("FAIL hit_prefetch: got n=%0d first=%h want n=1 first=00012", txn_q.size(), txn_q[0]); else n_pass++;
    endtask

    task automatic test_miss_replace();
        logic w0; logic [7:0] got; logic [7:0] e; int cyc;
        txn_q.delete();
        do_read(25'h200, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (w0 !== 1'b1) $display("FAIL miss_wait_strobe: got %b want 1", w0); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL miss_din: got %h want %h", got, e); else n_pass++;
        tick(8);
        n_checks++; if (txn_q.size() != 2 || txn_q[0] !== 17'h200 || txn_q[1] !== 17'h201) $display("FAIL miss_txns: got n=%0d %h %h want 00200 00201", txn_q.size(), txn_q[0], txn_q[1]); else n_pass++;
        do_read(25'h201, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (cyc != 0) $display("FAIL replaced_pf_cycles: got %0d want 0", cyc); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL replaced_pf_din: got %h want %h", got, e); else n_pass++;
        tick(8);
    endtask

    task automatic test_pending();
        logic w0; logic [7:0] got; logic [7:0] e; int cyc;
        lat = 3;
        do_read(25'h12, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (got !== e) $display("FAIL pend_setup_din: got %h want %h", got, e); else n_pass++;
        txn_q.delete();
        do_read(25'h13, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (w0 !== 1'b1) $display("FAIL pend_wait_strobe: got %b want 1", w0); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL pend_din: got %h want %h", got, e); else n_pass++;
        tick(8);
        n_checks++; if (txn_q.size() != 2 || txn_q[0] !== 17'h13 || txn_q[1] !== 17'h14) $display("FAIL pend_txns: got n=%0d %h %h want 00013 00014", txn_q.size(), txn_q[0], txn_q[1]); else n_pass++;
    endtask

    task automatic test_limit();
        logic w0; logic [7:0] got; logic [7:0] e; int cyc;
        txn_q.delete();
        do_read(25'h1FFFF, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (w0 !== 1'b1) $display("FAIL limit_wait_strobe: got %b want 1", w0); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL limit_din: got %h want %h", got, e); else n_pass++;
        tick(10);
        n_checks++; if (txn_q.size() != 1) $display("FAIL limit_no_prefetch: got %0d txns want 1", txn_q.size()); else n_pass++;
        do_read(25'h20000, w0, got, cyc);
        e = exp_q.pop_front();
        n_checks++; if (w0 !== 1'b0) $display("FAIL oor_wait_strobe: got %b want 0", w0); else n_pass++;
        n_checks++; if (cyc != 0) $display("FAIL oor_wait_cycles: got %0d want 0", cyc); else n_pass++;
        n_checks++; if (got !== e) $display("FAIL oor_din: got %h want %h", got, e); else n_pass++;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b1;
        ioctl_addr = 25'h50;
        ioctl_index = 8'h01;
        @(negedge clk_sys);
        n_checks++; if (ioctl_wait !== 1'b0) $display("FAIL idx_wait: got %b want 0", ioctl_wait); else n_pass++;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        ioctl_index = 8'h00;
        tick(6);
        n_checks++; if (ioctl_din !== 8'hFF) $display("FAIL idx_din: got %h want ff", ioctl_din); else n_pass++;
        n_checks++; if (txn_q.size() != 1) $display("FAIL idx_txns: got %0d want 1", txn_q.size()); else n_pass++;
    endtask

    task automatic test_sequential();
        logic w0; logic [7:0] got; logic [7:0] e; int cyc;
        lat = 2;
        for (int i = 0; i < 6; i++) begin
            do_read(25'h600 + 25'(i), w0, got, cyc);
            e = exp_q.pop_front();
            n_checks++; if (got !== e) $display("FAIL seq_din[%0d]: got %h want %h", i, got, e); else n_pass++;
            if (i == 0) begin
                n_checks++; if (w0 !== 1'b1) $display("FAIL seq_first_wait: got %b want 1", w0); else n_pass++;
            end else begin
                n_checks++; if (cyc != 0) $display("FAIL seq_cycles[%0d]: got %0d want 0", i, cyc); else n_pass++;
            end
            tick(6);
        end
    endtask

    task automatic test_drop_and_reset();
        logic [7:0] din_before;
        bit gone;
        lat = 6;
        din_before = ioctl_din;
        txn_q.delete();
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b1;
        ioctl_addr = 25'h300;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        @(posedge clk_sys);
        #1;
        ioctl_upload = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        n_checks++; if (ioctl_wait !== 1'b0) $display("FAIL drop_wait: got %b want 0", ioctl_wait); else n_pass++;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL drop_req_held: got %b want 1", mem_req); else n_pass++;
        gone = 1'b0;
        for (int i = 0; i < 20 && !gone; i++) begin
            @(negedge clk_sys);
            gone = !mem_req;
        end
        n_checks++; if (!gone) $display("FAIL drop_req_release: got req=%b want 0 within 20 cycles", mem_req); else n_pass++;
        tick(8);
        n_checks++; if (txn_q.size() != 1 || txn_q[0] !== 17'h300) $display("FAIL drop_txns: got n=%0d first=%h want n=1 first=00300", txn_q.size(), txn_q[0]); else n_pass++;
        n_checks++; if (ioctl_din !== din_before) $display("FAIL drop_din: got %h want %h", ioctl_din, din_before); else n_pass++;
        ioctl_upload = 1'b1;
        tick(2);
        ioctl_rd = 1'b1;
        ioctl_addr = 25'h400;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        @(posedge clk_sys);
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_setup_req: got %b want 1", mem_req); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (ioctl_din !== 8'h00) $display("FAIL rst_din: got %h want 00", ioctl_din); else n_pass++;
        n_checks++; if (ioctl_wait !== 1'b0) $display("FAIL rst_wait: got %b want 0", ioctl_wait); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 17'h0) $display("FAIL rst_addr: got %h want 0", mem_addr); else n_pass++;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_read();
        test_prefetch_hit();
        test_miss_replace();
        test_pending();
        test_limit();
        test_sequential();
        test_drop_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
